cpu_bootloader: RTL
===================

CPU_BOOTLOADER -- requirements
Module: cpu_bootloader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, meaning width of one program-memory word.
REQ-002 SHALL have parameter MEMORY_ADDRESS_WIDTH, default 4, meaning program-memory address width.
REQ-003 SHALL have parameter MEMORY_REGISTERS, default 16, meaning number of words loaded per session (≤ 2^MEMORY_ADDRESS_WIDTH).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  level, synchronous; begins or restarts a load session.
REQ-007 SHALL have port strobe_i  input  1  asynchronous pin; each rising edge delivers one data word.
REQ-008 SHALL have port data_i  input  DATA_WIDTH  pin data; sampled when a strobe edge is detected.
REQ-009 SHALL have port bl_programm_o  output  1  high while the CPU is held in programming mode.
REQ-010 SHALL have port bl_address_o  output  MEMORY_ADDRESS_WIDTH  write address to CPU memory.
REQ-011 SHALL have port bl_data_o  output  DATA_WIDTH  write data to CPU memory.
REQ-012 SHALL have port bl_write_en_mem_o  output  1  one-cycle memory write pulse.
REQ-013 SHALL have port done_o  output  1  high after a complete, accepted session.
REQ-014 SHALL have port error_o  output  1  checksum mismatch flag (see Configuration).

Function
REQ-015 SHALL synchronise strobe_i through two flip-flops, then detect a rising edge with a third; data_i sampled into a word register on the cycle the edge is detected.
REQ-016 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-017 IDLE: bl_programm_o=0; start_i=1 -> RECV, address counter cleared to 0, done_o and error_o cleared.
REQ-018 RECV: bl_programm_o=1; detected strobe edge -> WRITE with captured word; no edge -> remain.
REQ-019 WRITE (exactly one cycle): bl_write_en_mem_o=1, bl_address_o=counter, bl_data_o=captured word; next: counter==MEMORY_REGISTERS-1 -> CHECK (macro defined) or DONE (macro undefined), else counter+1 and -> RECV.
REQ-020 Address counter SHALL wrap to 0 only via a new session, never by overflow; bl_address_o and bl_data_o hold last values outside WRITE.
REQ-021 DONE: bl_programm_o=0, done_o=1; start_i=1 -> new session per REQ-017.
REQ-022 start_i=1 in RECV, WRITE or CHECK SHALL restart the session (counter 0, state RECV); a WRITE in progress on that cycle still completes its pulse.
REQ-023 Strobe edges in IDLE, WRITE or DONE SHALL be ignored and not queued.
REQ-024 bl_write_en_mem_o SHALL never be high for two consecutive cycles.

Reset
REQ-025 reset_i=1 SHALL force state IDLE, counter 0, synchroniser flops 0, and all outputs 0 on the next rising edge, overriding every other input, including mid-session.

Configuration
REQ-026 With macro CPU_BOOTLOADER_CHECKSUM_EN defined: running XOR of all written words kept; in CHECK, the next strobe word compared to it: equal -> DONE, unequal -> error_o=1 and IDLE with bl_programm_o=0.
REQ-027 Without CPU_BOOTLOADER_CHECKSUM_EN: no CHECK state or XOR register; WRITE of last word -> DONE; error_o tied 0.

Verification
REQ-028 Reset mid-RECV after 5 words -> next cycle all outputs 0, state IDLE; following strobes produce no write pulse.
REQ-029 start_i pulse, 16 strobes with data 0..15 (each held ≥4 cycles) -> 16 single-cycle write pulses, addresses 0..15 matching data, done_o=1, bl_programm_o=0 (macro undefined).
REQ-030 Macro defined, same 16 words then checksum 4'h0 -> done_o=1, error_o=0; checksum 4'h5 -> error_o=1, done_o=0, bl_programm_o=0.
REQ-031 start_i reasserted after 7 words -> next write pulse at address 0 with new data.
REQ-032 Strobe high held for 20 cycles -> exactly one write pulse; strobes in DONE -> no pulse, bl_address_o unchanged.

Source files
------------

// File: rtl/cpu_bootloader.sv
// -----------------------------------------------------------------------------
// cpu_bootloader
//
// Loads a program image into CPU memory from a slow external pin interface.
// An external host raises start_i, then clocks words in on data_i using the
// asynchronous strobe_i pin. Each word is written to consecutive memory
// addresses with a single-cycle write pulse. While loading, the CPU is held in
// programming mode through bl_programm_o.
//
// Optional feature (macro CPU_BOOTLOADER_CHECKSUM_EN):
//   After the last word, one more strobed word is taken as a checksum. It is
//   compared with the XOR of all written words. A match ends in DONE. A
//   mismatch raises error_o and returns to IDLE. Without the macro, the last
//   write goes directly to DONE and error_o is tied low.
//
// Ports
//   clk_i              single clock, rising edge
//   reset_i            synchronous active-high reset
//   start_i            level; begins or restarts a load session in any state
//   strobe_i           asynchronous pin; each rising edge delivers one word
//   data_i             pin data, sampled on the cycle a strobe edge is detected
//   bl_programm_o      high while the CPU is held in programming mode
//   bl_address_o       memory write address (holds outside WRITE)
//   bl_data_o          memory write data (holds outside WRITE)
//   bl_write_en_mem_o  one-cycle memory write pulse
//   done_o             high after a complete, accepted session
//   error_o            checksum mismatch flag
// -----------------------------------------------------------------------------
module cpu_bootloader #(
   parameter int DATA_WIDTH           = 4,
   parameter int MEMORY_ADDRESS_WIDTH = 4,
   parameter int MEMORY_REGISTERS     = 16
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            start_i,
   input  logic                            strobe_i,
   input  logic [DATA_WIDTH-1:0]           data_i,
   output logic                            bl_programm_o,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
   output logic [DATA_WIDTH-1:0]           bl_data_o,
   output logic                            bl_write_en_mem_o,
   output logic                            done_o,
   output logic                            error_o
);

   localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
      MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
   localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ZERO = {MEMORY_ADDRESS_WIDTH{1'b0}};
   localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ONE  = MEMORY_ADDRESS_WIDTH'(1'b1);
   localparam logic [DATA_WIDTH-1:0]           DATA_ZERO = {DATA_WIDTH{1'b0}};

`ifdef CPU_BOOTLOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Accumulates the running checksum over one more written word.
   function automatic logic [DATA_WIDTH-1:0] checksum_step(
      input logic [DATA_WIDTH-1:0] acc,
      input logic [DATA_WIDTH-1:0] word
   );
      return acc ^ word;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd4
   } state_t;
`endif

   state_t                          state_r;
   state_t                          state_next_s;
   logic [MEMORY_ADDRESS_WIDTH-1:0] count_r;
   logic [MEMORY_ADDRESS_WIDTH-1:0] count_next_s;
   logic [DATA_WIDTH-1:0]           word_r;
   logic [DATA_WIDTH-1:0]           word_next_s;
   logic [MEMORY_ADDRESS_WIDTH-1:0] addr_next_s;
   logic [DATA_WIDTH-1:0]           data_next_s;
   logic                            done_next_s;
   logic                            we_next_s;
   logic                            prog_next_s;

   logic                            strobe_meta_r;
   logic                            strobe_sync_r;
   logic                            strobe_prev_r;
   logic                            strobe_edge_s;

`ifdef CPU_BOOTLOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]           xor_r;
   logic [DATA_WIDTH-1:0]           xor_next_s;
   logic                            error_r;
   logic                            error_next_s;
`endif

   // Two-flop synchroniser for the strobe pin plus a third flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         strobe_meta_r <= 1'b0;
         strobe_sync_r <= 1'b0;
         strobe_prev_r <= 1'b0;
      end else begin
         strobe_meta_r <= strobe_i;
         strobe_sync_r <= strobe_meta_r;
         strobe_prev_r <= strobe_sync_r;
      end
   end

   assign strobe_edge_s = strobe_sync_r & ~strobe_prev_r;

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered, so the registered outputs line up with that state.
   always_comb begin
      state_next_s = state_r;
      count_next_s = count_r;
      word_next_s  = word_r;
      addr_next_s  = bl_address_o;
      data_next_s  = bl_data_o;
      done_next_s  = done_o;
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
      xor_next_s   = xor_r;
      error_next_s = error_r;
`endif

      if (strobe_edge_s) begin
         word_next_s = data_i;
      end else begin
         word_next_s = word_r;
      end

      // start_i restarts the session from every state; a WRITE already
      // under way has its pulse on the output this cycle, so it completes.
      if (start_i) begin
         state_next_s = ST_RECV;
         count_next_s = ADDR_ZERO;
         done_next_s  = 1'b0;
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
         xor_next_s   = DATA_ZERO;
         error_next_s = 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s = ST_IDLE;
            end
            ST_RECV: begin
               if (strobe_edge_s) begin
                  state_next_s = ST_WRITE;
                  addr_next_s  = count_r;
                  data_next_s  = word_next_s;
               end else begin
                  state_next_s = ST_RECV;
               end
            end
            ST_WRITE: begin
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
               xor_next_s = checksum_step(xor_r, bl_data_o);
`endif
               if (count_r == LAST_ADDR) begin
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
                  state_next_s = ST_CHECK;
`else
                  state_next_s = ST_DONE;
                  done_next_s  = 1'b1;
`endif
               end else begin
                  count_next_s = count_r + ADDR_ONE;
                  state_next_s = ST_RECV;
               end
            end
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (strobe_edge_s) begin
                  if (word_next_s == xor_r) begin
                     state_next_s = ST_DONE;
                     done_next_s  = 1'b1;
                  end else begin
                     state_next_s = ST_IDLE;
                     error_next_s = 1'b1;
                  end
               end else begin
                  state_next_s = ST_CHECK;
               end
            end
`endif
            ST_DONE: begin
               state_next_s = ST_DONE;
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end

      we_next_s   = (state_next_s == ST_WRITE);
      prog_next_s = (state_next_s == ST_RECV) || (state_next_s == ST_WRITE);
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
      prog_next_s = prog_next_s | (state_next_s == ST_CHECK);
`endif
   end

   // State, counter, captured word and registered outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r           <= ST_IDLE;
         count_r           <= ADDR_ZERO;
         word_r            <= DATA_ZERO;
         bl_programm_o     <= 1'b0;
         bl_address_o      <= ADDR_ZERO;
         bl_data_o         <= DATA_ZERO;
         bl_write_en_mem_o <= 1'b0;
         done_o            <= 1'b0;
      end else begin
         state_r           <= state_next_s;
         count_r           <= count_next_s;
         word_r            <= word_next_s;
         bl_programm_o     <= prog_next_s;
         bl_address_o      <= addr_next_s;
         bl_data_o         <= data_next_s;
         bl_write_en_mem_o <= we_next_s;
         done_o            <= done_next_s;
      end
   end

`ifdef CPU_BOOTLOADER_CHECKSUM_EN
   // Running checksum and mismatch flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         xor_r   <= DATA_ZERO;
         error_r <= 1'b0;
      end else begin
         xor_r   <= xor_next_s;
         error_r <= error_next_s;
      end
   end

   assign error_o = error_r;
`else
   assign error_o = 1'b0;
`endif

endmodule
